// File: rtl/hs_pkg.sv
// Shared definitions for the hs_req_tx 4-phase request sender.
//   hs_state_t     : sender FSM state encoding (2 bits)
//   HS_SYNC_STAGES : depth of the ack synchronizer
//   HS_CNT_W       : width of the optional wait-timeout counter
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } hs_state_t;

  localparam int HS_SYNC_STAGES = 2;
  localparam int HS_CNT_W       = 16;

endpackage

// File: rtl/hs_req_tx_if.sv
// Handshake bundle for hs_req_tx.
//   s_valid/s_data/s_ready : local word hand-off into the sender
//   req/data_out           : request and held word towards the remote domain
//   ack                    : asynchronous acknowledge from the remote domain
//   done                   : one-cycle completion pulse
//   err                    : sticky timeout flag (0 when the timeout is not built)
// slave is the sender's view; master is the environment's view.
interface hs_req_tx_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              req;
  logic [DATA_W-1:0] data_out;
  logic              ack;
  logic              done;
  logic              err;

  modport slave (
    input  s_valid, s_data, ack,
    output s_ready, req, data_out, done, err
  );

  modport master (
    output s_valid, s_data, ack,
    input  s_ready, req, data_out, done, err
  );
endinterface

// File: rtl/hs_sync_sr.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset.
//   clk      : destination clock
//   R        : synchronous active-high reset, clears every stage
//   sig      : asynchronous input
//   sig_sync : sig delayed through HS_SYNC_STAGES flops (first stage is the metastable one)
module hs_sync_sr
  import hs_pkg::*;
(
  input  logic clk,
  input  logic R,
  input  logic sig,
  output logic sig_sync
);

  logic [HS_SYNC_STAGES-1:0] stage_q;
  logic [HS_SYNC_STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[HS_SYNC_STAGES-2:0], sig};
  end

  // NOTE: flops are written with <= so every stage samples the pre-edge value
  // of its neighbour; blocking assignment here would collapse the chain.
  always_ff @(posedge clk) begin
    if (R) stage_q <= '0;
    else   stage_q <= stage_d;
  end

  assign sig_sync = stage_q[HS_SYNC_STAGES-1];

endmodule

// File: rtl/hs_req_tx.sv
// Sending side of a 4-phase req/ack handshake. A word taken on the local
// valid/ready side is held on data_out while req is driven; the remote ack is
// synchronized into clk and only the synchronized copy is ever used.
//   clk  : system clock
//   R    : synchronous active-high reset (priority over every transition)
//   bus  : hs_req_tx_if.slave (s_valid, s_data, s_ready, req, data_out, ack, done, err)
// Build option: define HS_TIMEOUT_EN to build a wait-state timeout that sets
// the sticky err flag; without it err is constant 0 and waits are unbounded.
module hs_req_tx
  import hs_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       R,
  hs_req_tx_if.slave bus
);

  logic              ack_sync;
  hs_state_t         state_q, state_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              s_ready;

  hs_sync_sr u_ack_sync (
    .clk      (clk),
    .R        (R),
    .sig      (bus.ack),
    .sig_sync (ack_sync)
  );

`ifdef HS_TIMEOUT_EN
  localparam logic [HS_CNT_W-1:0] CNT_LAST = HS_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [HS_CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                timeout_hit;

  assign timeout_hit = (cnt_q == CNT_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    s_ready = 1'b0;
`ifdef HS_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        // A still-high ack (including a spurious one) blocks the next request.
        s_ready = ~ack_sync;
        if (bus.s_valid && !ack_sync) begin
          data_d  = bus.s_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = WAIT_LOW;
        end
`ifdef HS_TIMEOUT_EN
        else if (timeout_hit) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = WAIT_LOW;
        end
`endif
      end
      WAIT_LOW: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef HS_TIMEOUT_EN
        else if (timeout_hit) begin
          err_d = 1'b1;
        end
`endif
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef HS_TIMEOUT_EN
  // Restart on every state change; count while waiting and park on the
  // terminal value so a long WAIT_LOW does not wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)                   cnt_d = '0;
    else if (state_q != IDLE && !timeout_hit) cnt_d = cnt_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the data register is reset on purpose; data_out is observable
      // and must read 0 after reset rather than a stale word.
      data_q  <= '0;
`ifdef HS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      data_q  <= data_d;
`ifdef HS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.req      = req_q;
  assign bus.data_out = data_q;
  assign bus.done     = done_q;
`ifdef HS_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_hs_req_tx.sv
// Self-checking bench for hs_req_tx. Inputs are driven and outputs sampled on
// the falling edge; a scoreboard queue holds words offered to the sender and
// is popped when req rises, and every done pulse is matched to that word.
module tb_hs_req_tx;

  localparam int DATA_W = 8;
  localparam int TO_CYC = 16;
`ifdef HS_TIMEOUT_EN
  localparam int MAX_DLY = 10;
`else
  localparam int MAX_DLY = 50;
`endif

  logic clk = 1'b0;
  logic R   = 1'b1;

  always #5 clk = ~clk;

  hs_req_tx_if #(.DATA_W(DATA_W)) bus ();

  hs_req_tx #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  int          exp_done = 0;
  logic [7:0]  sb_q[$];
  bit          r_at_edge = 1'b1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reset seen by the DUT at the latest rising edge.
  always @(posedge clk) r_at_edge <= R;

  // Monitor: data order, data stability and done pulses.
  initial begin
    logic       req_prev  = 1'b0;
    logic       done_prev = 1'b0;
    logic [7:0] data_prev = '0;
    logic [7:0] cur       = '0;
    bit         inflight  = 1'b0;
    forever begin
      @(negedge clk);
      if (r_at_edge) begin
        inflight = 1'b0;
      end else begin
        if (bus.req === 1'b1 && req_prev !== 1'b1) begin
          check("sb_pending", sb_q.size() > 0, 1'b1);
          if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            check("data_at_req", bus.data_out, cur);
            inflight = 1'b1;
          end
        end else begin
          check("data_stable", bus.data_out, data_prev);
        end
        if (bus.done === 1'b1) begin
          check("done_single", done_prev, 1'b0);
          check("done_inflight", inflight, 1'b1);
          check("done_data", bus.data_out, cur);
          inflight = 1'b0;
          n_done++;
        end
      end
      req_prev  = bus.req;
      done_prev = bus.done;
      data_prev = bus.data_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_req(input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req !== lvl && n < 200);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 200);
  endtask

  // Remote responder part of a transfer; entered on the sample where req is first high.
  task automatic finish_xfer(input logic [7:0] w, input int rise_d, input int fall_d,
                             input bit keep_valid, input logic [7:0] next_w);
    int n;
    if (keep_valid) bus.s_data = next_w;
    else            bus.s_valid = 1'b0;
    for (int i = 0; i < rise_d; i++) begin
      @(negedge clk);
      check("req_hold", bus.req, 1'b1);
      check("data_hold", bus.data_out, w);
    end
    bus.ack = 1'b1;
    wait_req(1'b0, n);
    check("ack_rise_to_req_fall", n, 3);
    check("data_after_req_fall", bus.data_out, w);
    for (int i = 0; i < fall_d; i++) begin
      @(negedge clk);
      check("wait_low_req", bus.req, 1'b0);
    end
    bus.ack = 1'b0;
    exp_done++;
    wait_done(n);
    check("ack_fall_to_done", n, 3);
    check("ready_with_done", bus.s_ready, 1'b1);
  endtask

  task automatic xfer(input logic [7:0] w, input int rise_d, input int fall_d,
                      input bit keep_valid, input logic [7:0] next_w);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    sb_q.push_back(w);
    wait_req(1'b1, n);
    check("accept_to_req", n, 1);
    finish_xfer(w, rise_d, fall_d, keep_valid, next_w);
  endtask

  initial begin
    int         n;
    int         d0;
    int         hi;
    logic [7:0] cur_w;
    logic [7:0] nxt_w;
    bit         keep;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.ack     = 1'b0;
    R           = 1'b1;
    repeat (3) @(negedge clk);
    R = 1'b0;
    check("rst_req", bus.req, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_data", bus.data_out, 8'h00);
    check("rst_ready", bus.s_ready, 1'b1);

    // Single transfer with a 3-cycle responder.
    xfer(8'hA5, 3, 3, 1'b0, 8'h00);

    // Back-to-back words with s_valid held high.
    d0 = n_done;
    xfer(8'h01, 3, 3, 1'b1, 8'h02);
    xfer(8'h02, 3, 3, 1'b1, 8'h03);
    xfer(8'h03, 3, 3, 1'b0, 8'h00);
    check("b2b_done_count", n_done - d0, 3);

    // ack high while idle blocks acceptance.
    bus.ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h3C;
    sb_q.push_back(8'h3C);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("ack_hi_ready", bus.s_ready, 1'b0);
      check("ack_hi_req", bus.req, 1'b0);
    end
    bus.ack = 1'b0;
    wait_req(1'b1, n);
    check("ack_release_to_accept", n, 3);
    finish_xfer(8'h3C, 3, 3, 1'b0, 8'h00);

    // Reset in REQ drops the transfer.
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hC3;
    sb_q.push_back(8'hC3);
    wait_req(1'b1, n);
    check("pre_rst_accept", n, 1);
    bus.s_valid = 1'b0;
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
    check("mid_rst_req", bus.req, 1'b0);
    check("mid_rst_data", bus.data_out, 8'h00);
    check("mid_rst_ready", bus.s_ready, 1'b1);
    check("mid_rst_done", bus.done, 1'b0);
    xfer(8'h5A, 3, 3, 1'b0, 8'h00);

    // Random ack delays.
    cur_w = 8'($urandom);
    for (int i = 0; i < 200; i++) begin
      nxt_w = 8'($urandom);
      keep  = (i < 199) && ($urandom_range(0, 1) == 1);
      xfer(cur_w, $urandom_range(0, MAX_DLY), $urandom_range(0, MAX_DLY), keep, nxt_w);
      cur_w = nxt_w;
    end
    check("err_after_random", bus.err, 1'b0);

    // Remote side never acknowledges.
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    sb_q.push_back(8'h77);
    wait_req(1'b1, n);
    check("noack_accept", n, 1);
    bus.s_valid = 1'b0;
`ifdef HS_TIMEOUT_EN
    wait_req(1'b0, n);
    check("timeout_req_fall", n, TO_CYC);
    check("timeout_err", bus.err, 1'b1);
    exp_done++;
    @(negedge clk);
    check("timeout_done", bus.done, 1'b1);
    repeat (5) @(negedge clk);
    check("err_sticky", bus.err, 1'b1);
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
    check("err_cleared_by_reset", bus.err, 1'b0);
`else
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.req === 1'b1 && bus.err === 1'b0) hi++;
    end
    check("req_held_1000", hi, 1000);
    check("noack_err", bus.err, 1'b0);
    finish_xfer(8'h77, 0, 0, 1'b0, 8'h00);
`endif

    repeat (3) @(negedge clk);
    check("done_total", n_done, exp_done);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
